keypad_scanner: RTL and testbench

//  Matrix-keypad reader for the lock front panel (4x4 Pmod KYPD). Strobes one column at a time,

---
 rtl/keypad_if.sv | 12 +
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_if.sv
// Keypad panel bundle: active-low row sense lines in, active-low column strobes and decoded key out.
// The scanner uses the master view; the panel/consumer side uses the slave view.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] column;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  modport master (input row, output column, key, key_valid, key_held);
  modport slave  (output row, input column, key, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes one column per slot, samples rows on the slot's last cycle,
// classifies each full scan and debounces presses/releases across consecutive scans.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic     clk,
  input  logic     srst,
  keypad_if.master kp
);

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

  // Rows 0..2 of columns 0..2 form the digit block 1..9; row 3 and column 3 are special.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    if (c == 2'd3)      key_map = 4'hA + {2'b00, r};
    else if (r == 2'd3) key_map = (c == 2'd0) ? 4'h0 : (c == 2'd1) ? 4'hF : 4'hE;
    else                key_map = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
  endfunction

  logic [3:0]        row_meta_reg, row_sync_reg;
  logic [TICK_W-1:0] tick_reg;
  logic [1:0]        col_reg;
  logic [1:0]        acc_cnt_reg;
  logic [3:0]        acc_code_reg;
  state_t            state_reg, state_next;
  logic [3:0]        cand_reg, cand_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  rel_reg, rel_next;
  logic [3:0]        key_reg, key_next;
  logic              key_valid_reg, key_valid_next;

  logic       slot_end, scan_end;
  logic [3:0] row_code [4];
  logic [2:0] sample_cnt, sum_cnt;
  logic [3:0] sample_code, merged_code;
  logic [1:0] total_cnt;
  logic       scan_none, scan_single;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_code
      assign row_code[gi] = key_map(2'(gi), col_reg);
    end
  endgenerate

  assign slot_end = (tick_reg == TICK_LAST);
  assign scan_end = slot_end && (col_reg == 2'd3);

  always_comb begin
    sample_cnt  = '0;
    sample_code = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_reg[r]) begin
        sample_cnt  = sample_cnt + 3'd1;
        sample_code = row_code[r];
      end
    end
  end

  // Running low-bit count saturates at 2: anything beyond one press is simply MULTI.
  assign sum_cnt     = {1'b0, acc_cnt_reg} + sample_cnt;
  assign total_cnt   = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
  assign merged_code = (acc_cnt_reg == 2'd0) ? sample_code : acc_code_reg;
  assign scan_none   = (total_cnt == 2'd0);
  assign scan_single = (total_cnt == 2'd1);

  always_ff @(posedge clk) begin
    if (srst) begin
      row_meta_reg  <= '0;
      row_sync_reg  <= '0;
      tick_reg      <= '0;
      col_reg       <= '0;
      acc_cnt_reg   <= '0;
      acc_code_reg  <= '0;
      state_reg     <= IDLE;
      cand_reg      <= '0;
      cnt_reg       <= '0;
      rel_reg       <= '0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
    end else begin
      row_meta_reg <= kp.row;
      row_sync_reg <= row_meta_reg;
      if (slot_end) begin
        tick_reg <= '0;
        col_reg  <= col_reg + 2'd1;
      end else begin
        tick_reg <= tick_reg + TICK_ONE;
      end
      if (scan_end) begin
        acc_cnt_reg  <= '0;
        acc_code_reg <= '0;
      end else if (slot_end) begin
        acc_cnt_reg  <= total_cnt;
        acc_code_reg <= merged_code;
      end
      state_reg     <= state_next;
      cand_reg      <= cand_next;
      cnt_reg       <= cnt_next;
      rel_reg       <= rel_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cand_next      = cand_reg;
    cnt_next       = cnt_reg;
    rel_next       = rel_reg;
    key_next       = key_reg;
    key_valid_next = 1'b0;
    if (scan_end) begin
      unique case (state_reg)
        IDLE: begin
          if (scan_single) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_next     = PRESSED;
              key_next       = merged_code;
              key_valid_next = 1'b1;
              rel_next       = '0;
            end else begin
              state_next = DEBOUNCE;
              cand_next  = merged_code;
              cnt_next   = CNT_ONE;
            end
          end
        end
        DEBOUNCE: begin
          if (!scan_single) begin
            state_next = IDLE;
          end else if (merged_code != cand_reg) begin
            cand_next = merged_code;
            cnt_next  = CNT_ONE;
          end else if (cnt_reg + CNT_ONE == CNT_DONE) begin
            state_next     = PRESSED;
            key_next       = cand_reg;
            key_valid_next = 1'b1;
            rel_next       = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        PRESSED: begin
          // MULTI keeps the release count at zero just like a held single key.
          if (!scan_none) begin
            rel_next = '0;
          end else if (rel_reg + CNT_ONE == CNT_DONE) begin
            state_next = IDLE;
            rel_next   = '0;
          end else begin
            rel_next = rel_reg + CNT_ONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign kp.column    = ~(4'b0001 << col_reg);
  assign kp.key       = key_reg;
  assign kp.key_valid = key_valid_reg;
  assign kp.key_held  = (state_reg == PRESSED);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad wired to the column strobes.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        srst;
  logic [15:0] pressed;   // bit r*4+c set while key(r,c) is held down
  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;
  int          doubles = 0;
  logic        prev_valid = 1'b0;

  keypad_if kp ();

  keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_SCANS(2)) dut (
    .clk  (clk),
    .srst (srst),
    .kp   (kp)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.column[c]) kp.row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (kp.key_valid) begin
      pulses <= pulses + 1;
      if (prev_valid) doubles <= doubles + 1;
    end
    prev_valid <= kp.key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle of a new scan (column 0 slot, tick 0).
  task automatic align();
    logic [3:0] prev;
    prev = kp.column;
    for (int g = 0; g < 64; g++) begin
      step(1);
      if (kp.column == 4'b1110 && prev == 4'b0111) return;
      prev = kp.column;
    end
    check("align_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'd1;
    return one << (r * 4 + c);
  endfunction

  logic [3:0] cols [4];

  initial begin
    cols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    srst = 1'b1;
    pressed = '0;

    // 1: reset values and column stepping
    step(3);
    srst = 1'b0;
    check("rst_column", 32'(kp.column), 32'(4'b1110));
    check("rst_key", 32'(kp.key), 32'h0);
    check("rst_valid", 32'(kp.key_valid), 32'h0);
    check("rst_held", 32'(kp.key_held), 32'h0);
    for (int i = 0; i < 5; i++) begin
      check("col_step", 32'(kp.column), 32'(cols[i % 4]));
      step(4);
    end

    // 2: press '5' for 10 scans, strobe after the 2nd full scan
    align();
    pressed = key_bit(1, 1);
    step(32);
    check("p5_valid_edge", 32'(kp.key_valid), 32'h1);
    check("p5_no_early_pulse", 32'(pulses), 32'd0);
    step(1);
    check("p5_valid_drop", 32'(kp.key_valid), 32'h0);
    check("p5_pulses", 32'(pulses), 32'd1);
    check("p5_key", 32'(kp.key), 32'h5);
    check("p5_held", 32'(kp.key_held), 32'h1);
    step(127);
    check("p5_held_late", 32'(kp.key_held), 32'h1);
    check("p5_pulses_late", 32'(pulses), 32'd1);
    pressed = '0;
    step(56);
    check("p5_released", 32'(kp.key_held), 32'h0);

    // 3: bounce '9', then a clean hold
    align();
    pressed = key_bit(2, 2);
    step(16);
    pressed = '0;
    step(16);
    pressed = key_bit(2, 2);
    step(16);
    check("b9_no_pulse", 32'(pulses), 32'd1);
    step(17);
    check("b9_pulse", 32'(pulses), 32'd2);
    check("b9_key", 32'(kp.key), 32'h9);
    step(15);
    pressed = '0;
    step(56);

    // 4: '1' and '2' together
    align();
    pressed = key_bit(0, 0) | key_bit(0, 1);
    step(80);
    check("multi_pulses", 32'(pulses), 32'd2);
    check("multi_held", 32'(kp.key_held), 32'h0);
    check("multi_key", 32'(kp.key), 32'h9);
    align();
    pressed = '0;
    step(32);

    // 5: 'A' while '5' held, release timing, then fresh 'A'
    align();
    pressed = key_bit(1, 1);
    step(33);
    check("h5_pulses", 32'(pulses), 32'd3);
    check("h5_key", 32'(kp.key), 32'h5);
    pressed = pressed | key_bit(0, 3);
    step(64);
    check("h5a_pulses", 32'(pulses), 32'd3);
    check("h5a_key", 32'(kp.key), 32'h5);
    check("h5a_held", 32'(kp.key_held), 32'h1);
    align();
    pressed = '0;
    step(31);
    check("rel_held_before", 32'(kp.key_held), 32'h1);
    step(1);
    check("rel_held_after", 32'(kp.key_held), 32'h0);
    align();
    pressed = key_bit(0, 3);
    step(33);
    check("pa_pulses", 32'(pulses), 32'd4);
    check("pa_key", 32'(kp.key), 32'hA);
    pressed = '0;
    step(56);

    // 6: reset while debouncing '7'
    align();
    pressed = key_bit(2, 0);
    step(20);
    srst = 1'b1;
    step(1);
    check("mid_rst_column", 32'(kp.column), 32'(4'b1110));
    check("mid_rst_key", 32'(kp.key), 32'h0);
    check("mid_rst_valid", 32'(kp.key_valid), 32'h0);
    check("mid_rst_held", 32'(kp.key_held), 32'h0);
    srst = 1'b0;
    pressed = '0;
    step(64);
    check("mid_rst_no_pulse", 32'(pulses), 32'd4);
    align();
    pressed = key_bit(2, 0);
    step(32);
    check("p7_valid_edge", 32'(kp.key_valid), 32'h1);
    step(1);
    check("p7_pulses", 32'(pulses), 32'd5);
    check("p7_key", 32'(kp.key), 32'h7);
    check("no_double_valid", 32'(doubles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
